cache_way_allocator: RTL

- Per-set victim-way allocator for the set-associative cache.
- Is the expanding counterpart of the word-reduction logic on the hit path. Hit detection collapses per-way compare bits into one hit bit. This block takes a miss and expands it back into a one-hot way-enable for line fill.
- Tracks per-way valid bits and true-LRU ages per set.
- Offers the chosen victim way to the fill controller over a valid/ready handshake.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_way_allocator_pick.sv | 15 +
 rtl/cache_way_allocator.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache way allocator: default geometry,
// allocator state encoding and the per-set age array type.
package cache_pkg;

  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    OFFER
  } alloc_state_e;

  // LRU ages of one set: 0 = most recent, WAYS-1 = least recent
  typedef logic [AGE_W-1:0] set_ages_t [WAYS];

endpackage

// File: rtl/cache_way_allocator_pick.sv
// Lowest-set-bit priority picker: turns any request vector into a one-hot
// grant of its lowest set bit, plus a flag saying whether any bit was set.
module onehot_lsb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);

  // Two's-complement trick isolates the lowest set bit
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/cache_way_allocator.sv
// Per-set victim-way allocator. Tracks per-way valid bits and true-LRU ages,
// picks a victim on a miss and offers it over a valid/ready handshake.
// Optional hit/miss/evict statistics counters: define CACHE_ALLOC_STATS_EN.
module cache_way_allocator #(
  parameter int WAYS  = cache_pkg::WAYS,
  parameter int SETS  = cache_pkg::SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acc_valid_i,
  input  logic [IDX_W-1:0] acc_index_i,
  input  logic             acc_hit_i,
  input  logic [WAYS-1:0]  acc_way_i,
  input  logic             inv_valid_i,
  input  logic [IDX_W-1:0] inv_index_i,
  input  logic [WAYS-1:0]  inv_way_i,
  output logic             alloc_valid_o,
  input  logic             alloc_ready_i,
  output logic [WAYS-1:0]  alloc_way_o,
  output logic [IDX_W-1:0] alloc_index_o,
  output logic             busy_o
`ifdef CACHE_ALLOC_STATS_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o,
  output logic [31:0]      evict_cnt_o
`endif
);

  import cache_pkg::*;

  alloc_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] alloc_index_q, alloc_index_d;
  logic [WAYS-1:0]  alloc_way_q, alloc_way_d;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  valid_d [SETS];
  logic [AGE_W-1:0] age_q [SETS][WAYS];
  logic [AGE_W-1:0] age_new [WAYS];

  logic [WAYS-1:0]  hit_oh, sel_valid, inv_pick, lru_oh, upd_oh;
  logic             hit_any, inv_any;
  logic             hit_acc, miss_acc, handshake, upd_en;
  logic [IDX_W-1:0] upd_set;
  logic [AGE_W-1:0] upd_age;

  onehot_lsb_pick #(.N(WAYS)) u_hit_pick (
    .req_i (acc_way_i),
    .gnt_o (hit_oh),
    .any_o (hit_any)
  );

  onehot_lsb_pick #(.N(WAYS)) u_inv_pick (
    .req_i (~sel_valid),
    .gnt_o (inv_pick),
    .any_o (inv_any)
  );

  assign hit_acc   = (state_q == IDLE) && acc_valid_i && acc_hit_i;
  assign miss_acc  = (state_q == IDLE) && acc_valid_i && !acc_hit_i;
  assign handshake = (state_q == OFFER) && alloc_ready_i;

  // Hits and fills share one age-update path; they never coincide
  assign upd_en  = (hit_acc && hit_any) || handshake;
  assign upd_set = handshake ? alloc_index_q : acc_index_i;
  assign upd_oh  = handshake ? alloc_way_q : hit_oh;

  // Victim candidates for the latched set; a same-cycle invalidate is visible
  always_comb begin
    sel_valid = valid_q[idx_q];
    if (inv_valid_i && (inv_index_i == idx_q)) begin
      sel_valid = sel_valid & ~inv_way_i;
    end
    lru_oh = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[idx_q][w] == AGE_W'(WAYS - 1)) begin
        lru_oh[w] = 1'b1;
      end
    end
  end

  // Move the touched way to age 0 and age every younger way by one
  always_comb begin
    upd_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (upd_oh[w]) begin
        upd_age = age_q[upd_set][w];
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      age_new[w] = age_q[upd_set][w];
      if (upd_oh[w]) begin
        age_new[w] = '0;
      end else if (age_q[upd_set][w] < upd_age) begin
        age_new[w] = age_q[upd_set][w] + AGE_W'(1);
      end
    end
  end

  // Valid bits: invalidate first, then a fill on the same way takes priority
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      valid_d[s] = valid_q[s];
    end
    if (inv_valid_i) begin
      valid_d[inv_index_i] = valid_d[inv_index_i] & ~inv_way_i;
    end
    if (handshake) begin
      valid_d[alloc_index_q] = valid_d[alloc_index_q] | alloc_way_q;
    end
  end

  // Allocator FSM next state and registered victim offer
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    alloc_way_d   = alloc_way_q;
    alloc_index_d = alloc_index_q;
    case (state_q)
      IDLE: begin
        if (miss_acc) begin
          state_d = SELECT;
          idx_d   = acc_index_i;
        end
      end
      SELECT: begin
        alloc_way_d   = inv_any ? inv_pick : lru_oh;
        alloc_index_d = idx_q;
        state_d       = OFFER;
      end
      OFFER: begin
        if (alloc_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and offer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      alloc_way_q   <= '0;
      alloc_index_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      alloc_way_q   <= alloc_way_d;
      alloc_index_q <= alloc_index_d;
    end
  end

  // Per-set valid bits and LRU ages; reset gives way i age i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= valid_d[s];
      end
      if (upd_en) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[upd_set][w] <= age_new[w];
        end
      end
    end
  end

  assign alloc_valid_o = (state_q == OFFER);
  assign alloc_way_o   = alloc_way_q;
  assign alloc_index_o = alloc_index_q;
  assign busy_o        = (state_q != IDLE);

`ifdef CACHE_ALLOC_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, evict_cnt_q;
  logic        victim_was_valid;

  assign victim_was_valid = |(valid_q[alloc_index_q] & alloc_way_q);

  // Free-running wrap-around statistics counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (hit_acc)                      hit_cnt_q   <= hit_cnt_q + 32'd1;
      if (miss_acc)                     miss_cnt_q  <= miss_cnt_q + 32'd1;
      if (handshake && victim_was_valid) evict_cnt_q <= evict_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;
  assign evict_cnt_o = evict_cnt_q;
`endif

endmodule
